// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter and registered command sequencer for the shared 8-bit on-chip SRAM s1 port.
// Defining SRAM_CLEAR_EN adds a frame-clear sequencer that fills DEPTH words with CLEAR_VALUE.
module sram_port_arbiter #(
  parameter int                NUM_REQ      = 4,
  parameter int                ADDR_W       = 17,
  parameter int                DATA_W       = 8,
  parameter int                READ_LATENCY = 2,
  parameter int                DEPTH        = 76800,
  parameter logic [DATA_W-1:0] CLEAR_VALUE  = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  output logic [ADDR_W-1:0]           sram_address,
  output logic                        sram_clken,
  output logic                        sram_chipselect,
  output logic                        sram_write,
  output logic [DATA_W-1:0]           sram_writedata,
  input  logic [DATA_W-1:0]           sram_readdata,
  input  logic                        clear_start,
  output logic                        clear_busy,
  output logic                        clear_done
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   cand_idx;
  logic               grant_found;
  logic [NUM_REQ-1:0] req_eligible;
  logic               clear_issue;
  logic [ADDR_W-1:0]  clear_addr;
  logic               cmd_read;
  logic [IDX_W-1:0]   cmd_idx;
  logic [READ_LATENCY-1:0] tag_vld;
  logic [IDX_W-1:0]   tag_idx [READ_LATENCY];

`ifdef SRAM_CLEAR_EN
  typedef enum logic {IDLE, CLEAR} clr_state_t;
  clr_state_t state, state_nxt;
  logic       clear_last;

  assign clear_last = (clear_addr == ADDR_W'(DEPTH - 1));
  assign clear_busy = clear_issue;

  // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
  always_comb begin
    state_nxt   = state;
    clear_issue = 1'b0;
    case (state)
      IDLE:  if (clear_start) state_nxt = CLEAR;
      CLEAR: begin
        clear_issue = 1'b1;
        if (clear_last) state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      clear_addr <= '0;
      clear_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      clear_done <= clear_issue && clear_last;
      if (clear_issue) clear_addr <= clear_last ? '0 : clear_addr + 1'b1;
    end
  end
`else
  logic unused_clear_cfg;
  assign clear_issue      = 1'b0;
  assign clear_addr       = '0;
  assign clear_busy       = 1'b0;
  assign clear_done       = 1'b0;
  assign unused_clear_cfg = ^{clear_start, DEPTH};
`endif

  // The clear sequencer owns the port while busy, so nobody is granted.
  assign req_eligible = req_valid & {NUM_REQ{~clear_busy}};

  always_comb begin
    grant_idx   = '0;
    grant_found = 1'b0;
    cand_idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_idx = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (!grant_found && req_eligible[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_found) req_ready[grant_idx] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sram_clken      <= 1'b0;
      sram_chipselect <= 1'b0;
      sram_write      <= 1'b0;
      sram_address    <= '0;
      sram_writedata  <= '0;
      cmd_read        <= 1'b0;
      cmd_idx         <= '0;
      last_grant      <= IDX_W'(NUM_REQ - 1);
    end else begin
      sram_clken <= 1'b1;
      cmd_read   <= 1'b0;
      if (clear_issue) begin
        sram_chipselect <= 1'b1;
        sram_write      <= 1'b1;
        sram_address    <= clear_addr;
        sram_writedata  <= CLEAR_VALUE;
      end else if (grant_found) begin
        sram_chipselect <= 1'b1;
        sram_write      <= req_write[grant_idx];
        sram_address    <= req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
        sram_writedata  <= req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
        cmd_read        <= ~req_write[grant_idx];
        cmd_idx         <= grant_idx;
        last_grant      <= grant_idx;
      end else begin
        sram_chipselect <= 1'b0;
        sram_write      <= 1'b0;
      end
    end
  end

  // NOTE: the tag pipeline is reset (unlike a data RAM) so reads in flight at reset never respond.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_vld   <= '0;
      for (int i = 0; i < READ_LATENCY; i++) tag_idx[i] <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      tag_vld[0] <= cmd_read;
      tag_idx[0] <= cmd_idx;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end
      rsp_valid <= '0;
      if (tag_vld[READ_LATENCY-1]) begin
        rsp_valid[tag_idx[READ_LATENCY-1]] <= 1'b1;
        rsp_data                           <= sram_readdata;
      end
    end
  end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: directed stimulus queues expected read responses,
// an independent monitor pops and compares them; clear tests run when SRAM_CLEAR_EN is defined.
module tb_sram_port_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 17;
  localparam int DATA_W  = 8;
  localparam int RL      = 2;
  localparam int DEPTH   = 16;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic [ADDR_W-1:0]         sram_address;
  logic                      sram_clken;
  logic                      sram_chipselect;
  logic                      sram_write;
  logic [DATA_W-1:0]         sram_writedata;
  logic [DATA_W-1:0]         sram_readdata;
  logic                      clear_start;
  logic                      clear_busy;
  logic                      clear_done;

  sram_port_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .READ_LATENCY(RL), .DEPTH(DEPTH), .CLEAR_VALUE(8'h00)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .sram_address(sram_address), .sram_clken(sram_clken), .sram_chipselect(sram_chipselect),
    .sram_write(sram_write), .sram_writedata(sram_writedata), .sram_readdata(sram_readdata),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done)
  );

  always #5 clk = ~clk;

  // SRAM model with a two-cycle read latency from the command cycle.
  logic [7:0] mem [0:(1<<ADDR_W)-1];
  logic [7:0] rd_p1;
  int         wr_cnt   = 0;
  int         done_cnt = 0;
  int         cyc      = 0;

  always @(posedge clk) begin
    if (sram_chipselect && sram_write) begin
      mem[sram_address] = sram_writedata;
      wr_cnt = wr_cnt + 1;
    end
  end
  always @(posedge clk) begin
    rd_p1         <= mem[sram_address];
    sram_readdata <= rd_p1;
  end
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (clear_done) done_cnt = done_cnt + 1;

  typedef struct {
    int         idx;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   base_wr, base_done, nz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && rsp_valid != '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'(rsp_valid), 32'h0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_valid", 32'(rsp_valid), 32'(1 << mon_e.idx));
        check("rsp_data", 32'(rsp_data), 32'(mon_e.data));
        check("rsp_latency", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  task automatic idle_inputs();
    req_valid   = '0;
    req_write   = '0;
    clear_start = 1'b0;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    req_valid[i]                  = 1'b1;
    req_write[i]                  = wr;
    req_addr[i*ADDR_W +: ADDR_W]  = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  // Called in the accept cycle; the response is due four cycles later.
  task automatic push_read(input int i, input logic [7:0] d);
    exp_q.push_back('{i, d, cyc + RL + 2});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    req_addr  = '0;
    req_wdata = '0;
    mem[17'h00010] = 8'hA5;
    for (int i = 0; i < 4; i++) mem[17'h20 + i] = 8'h50 + 8'(i);
    mem[17'h00100] = 8'hFF;
    mem[17'h00040] = 8'h77;

    repeat (2) @(negedge clk);
    check("reset_cs", 32'(sram_chipselect), 32'h0);
    check("reset_clken", 32'(sram_clken), 32'h0);
    check("reset_rsp", 32'(rsp_valid), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("clken_after_reset", 32'(sram_clken), 32'h1);
    check("idle_no_ready", 32'(req_ready), 32'h0);

    // Single read by requester 2.
    set_req(2, 1'b0, 17'h00010, 8'h00);
    #1 check("rd_ready", 32'(req_ready), 32'h4);
    push_read(2, 8'hA5);
    @(negedge clk);
    idle_inputs();
    check("rd_cmd", {sram_chipselect, sram_write, sram_address}, {1'b1, 1'b0, 17'h00010});
    repeat (6) @(negedge clk);

    // Fairness and fully pipelined reads from all four requesters.
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 17'h20 + 17'(i), 8'h00);
    for (int k = 0; k < 8; k++) begin
      #1 check($sformatf("fair_%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
      push_read(k % 4, 8'h50 + 8'(k % 4));
      @(negedge clk);
    end
    idle_inputs();
    repeat (8) @(negedge clk);

    // Write then read-after-write on consecutive accepts.
    set_req(0, 1'b1, 17'h00100, 8'h3C);
    #1 check("mix_wr_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    idle_inputs();
    set_req(1, 1'b0, 17'h00100, 8'h00);
    #1 check("mix_rd_ready", 32'(req_ready), 32'h2);
    push_read(1, 8'h3C);
    check("mix_wr_cmd", {sram_chipselect, sram_write, sram_address, sram_writedata},
          {1'b1, 1'b1, 17'h00100, 8'h3C});
    @(negedge clk);
    idle_inputs();
    #1 check("idle_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    check("idle_cmd_hold", {sram_chipselect, sram_write, sram_address}, {1'b0, 1'b0, 17'h00100});

    // Rotation and wrap-around of the round-robin pointer (last grant is 1 here).
    set_req(0, 1'b1, 17'h00200, 8'h01);
    set_req(1, 1'b1, 17'h00201, 8'h02);
    #1 check("rot_wrap_to_0", 32'(req_ready), 32'h1);
    @(negedge clk);
    #1 check("rot_next_1", 32'(req_ready), 32'h2);
    @(negedge clk);
    idle_inputs();
    set_req(0, 1'b1, 17'h00202, 8'h03);
    set_req(3, 1'b1, 17'h00203, 8'h04);
    #1 check("rot_skip_to_3", 32'(req_ready), 32'h8);
    @(negedge clk);
    #1 check("rot_wrap_3_to_0", 32'(req_ready), 32'h1);
    @(negedge clk);
    idle_inputs();
    repeat (6) @(negedge clk);

    // Reset while a read is in flight: no response, pointer back to requester 0 first.
    set_req(2, 1'b0, 17'h00040, 8'h00);
    #1 check("rst_rd_ready", 32'(req_ready), 32'h4);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    do_reset();
    repeat (8) @(negedge clk);
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 17'h00300 + 17'(i), 8'h10);
    #1 check("post_rst_grant", 32'(req_ready), 32'h1);
    @(negedge clk);
    idle_inputs();
    repeat (4) @(negedge clk);

`ifdef SRAM_CLEAR_EN
    // Frame clear with requester 3 waiting to read the last cleared word.
    for (int a = 0; a < DEPTH; a++) mem[a] = 8'hEE;
    base_wr   = wr_cnt;
    base_done = done_cnt;
    clear_start = 1'b1;
    @(negedge clk);
    clear_start = 1'b0;
    set_req(3, 1'b0, 17'(DEPTH - 1), 8'h00);
    for (int k = 0; k < DEPTH; k++) begin
      #1 check($sformatf("clr_busy_%0d", k), 32'(clear_busy), 32'h1);
      check($sformatf("clr_ready_%0d", k), 32'(req_ready), 32'h0);
      @(negedge clk);
    end
    #1 check("clr_busy_end", 32'(clear_busy), 32'h0);
    check("clr_done", 32'(clear_done), 32'h1);
    check("clr_grant", 32'(req_ready), 32'h8);
    push_read(3, 8'h00);
    @(negedge clk);
    idle_inputs();
    repeat (6) @(negedge clk);
    nz = 0;
    for (int a = 0; a < DEPTH; a++) if (mem[a] !== 8'h00) nz++;
    check("clr_fill", 32'(nz), 32'h0);
    check("clr_writes", 32'(wr_cnt - base_wr), 32'(DEPTH));
    check("clr_done_cnt", 32'(done_cnt - base_done), 32'h1);

    // A second clear_start during the clear is ignored.
    for (int a = 0; a < DEPTH; a++) mem[a] = 8'hEE;
    base_wr   = wr_cnt;
    base_done = done_cnt;
    clear_start = 1'b1;
    @(negedge clk);
    clear_start = 1'b0;
    repeat (4) @(negedge clk);
    clear_start = 1'b1;
    @(negedge clk);
    clear_start = 1'b0;
    repeat (20) @(negedge clk);
    nz = 0;
    for (int a = 0; a < DEPTH; a++) if (mem[a] !== 8'h00) nz++;
    check("restart_fill", 32'(nz), 32'h0);
    check("restart_writes", 32'(wr_cnt - base_wr), 32'(DEPTH));
    check("restart_done_cnt", 32'(done_cnt - base_done), 32'h1);
    check("restart_idle", 32'(clear_busy), 32'h0);
`endif

    repeat (8) @(negedge clk);
    check("sb_drain", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
